instr_encoder: RTL and testbench

- Producer side of the 8-bit instruction interface: packs opcode/reg_sel/operand field tuples into instruction bytes.
- Buffers packed bytes in a small FIFO and presents them to the decoder's instr_in/ena pins with a valid/ready handshake.
- Sits between the program sequencer/host loader and the decoder.
- Canonicalizes undefined encodings to NOP and flags them.

---
 rtl/instr_pkg.sv | 41 ++++
 rtl/instr_encoder_if.sv | 24 ++
 rtl/instr_fifo.sv | 99 +++++++++
 rtl/instr_encoder.sv | 62 ++++++
 tb/tb_instr_encoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-format constants and helpers for the 8-bit instruction
// interface, used by both the encoder and the decoder.
package instr_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam int OPC_HI     = 7;
  localparam int OPC_LO     = 5;
  localparam int REGSEL_BIT = 4;
  localparam int OPND_HI    = 3;
  localparam int OPND_LO    = 0;

  localparam logic [7:0] NOP_WORD = 8'hE0;

  // NOP carries no fields; any non-zero field makes it an undefined encoding.
  function automatic logic is_illegal(input logic [2:0] opcode, input logic reg_sel,
                                      input logic [3:0] operand);
    return (opcode == OP_NOP) && (reg_sel || (operand != 4'h0));
  endfunction

  function automatic logic [7:0] encode(input logic [2:0] opcode, input logic reg_sel,
                                        input logic [3:0] operand);
    logic [7:0] word;
    if (is_illegal(opcode, reg_sel, operand)) begin
      word = NOP_WORD;
    end else begin
      word[OPC_HI:OPC_LO]   = opcode;
      word[REGSEL_BIT]      = reg_sel;
      word[OPND_HI:OPND_LO] = operand;
    end
    return word;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake and packed-instruction output handshake of the
// instruction encoder.
interface instr_encoder_if;

  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic       in_reg_sel;
  logic [3:0] in_operand;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] instr_out;

  modport slave (
    input  in_valid, in_opcode, in_reg_sel, in_operand, out_ready,
    output in_ready, out_valid, instr_out
  );

  modport master (
    output in_valid, in_opcode, in_reg_sel, in_operand, out_ready,
    input  in_ready, out_valid, instr_out
  );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered head data, valid, ready and occupancy;
// flush clears occupancy and pointers on a clock edge.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             ready_r;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] remain_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;

  // Next-state pointers/count and the next head word (write-through when the
  // queue would otherwise be empty, so first-word latency is one edge).
  always_comb begin
    push_s   = wr_en && ready_r;
    pop_s    = valid_r && rd_en;
    remain_s = count_r - CNT_W'(pop_s);
    if (flush) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_s);
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
      count_nxt_s  = remain_s + CNT_W'(push_s);
    end
    if (flush || (count_nxt_s == {CNT_W{1'b0}})) begin
      data_nxt_s = data_r;
    end else if (remain_s == {CNT_W{1'b0}}) begin
      data_nxt_s = wr_data;
    end else begin
      data_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Pointers, occupancy and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      data_r   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ready_r  <= (count_nxt_s != CNT_W'(DEPTH));
      valid_r  <= (count_nxt_s != {CNT_W{1'b0}});
      data_r   <= data_nxt_s;
    end
  end

  assign wr_ready = ready_r;
  assign rd_valid = valid_r;
  assign rd_data  = data_r;
  assign count    = count_r;

endmodule

// File: rtl/instr_encoder.sv
// Packs opcode/reg_sel/operand tuples into instruction bytes, canonicalizes
// undefined encodings to NOP with a sticky flag, and queues them for the decoder.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  input  logic             flush,
  input  logic             err_clr,
  output logic             illegal_err,
  output logic [CNT_W-1:0] count
);

  logic [7:0] word_s;
  logic       illegal_s;
  logic       accept_s;
  logic       illegal_err_r;

  // Pack the incoming tuple; a flushed push is dropped and never counts as accepted.
  always_comb begin
    word_s    = encode(bus.in_opcode, bus.in_reg_sel, bus.in_operand);
    illegal_s = is_illegal(bus.in_opcode, bus.in_reg_sel, bus.in_operand);
    accept_s  = bus.in_valid && bus.in_ready && !flush;
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .WIDTH (8)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (bus.in_valid),
    .wr_data  (word_s),
    .wr_ready (bus.in_ready),
    .rd_en    (bus.out_ready),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.instr_out),
    .count    (count)
  );

  // Sticky illegal flag; a set on the same edge as a clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_err_r <= 1'b0;
    end else if (accept_s && illegal_s) begin
      illegal_err_r <= 1'b1;
    end else if (err_clr) begin
      illegal_err_r <= 1'b0;
    end else begin
      illegal_err_r <= illegal_err_r;
    end
  end

  assign illegal_err = illegal_err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: reset, packing, full/empty,
// illegal canonicalization, streaming, flush and asynchronous reset.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             err_clr;
  logic             illegal_err;
  logic [CNT_W-1:0] count;
  int               errors = 0;
  int               checks = 0;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .flush       (flush),
    .err_clr     (err_clr),
    .illegal_err (illegal_err),
    .count       (count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] opc, input logic rs, input logic [3:0] opnd);
    bus.in_valid   = v;
    bus.in_opcode  = opc;
    bus.in_reg_sel = rs;
    bus.in_operand = opnd;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; err_clr = 1'b0; bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 1'b1, 4'h3);
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (bus.instr_out !== 8'h00) begin errors++; $display("FAIL reset_instr_out: got %h exp 00", bus.instr_out); end
    checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL reset_illegal_err: got %b exp 0", illegal_err); end
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 3'b000, 1'b1, 4'h3);
    tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", bus.out_valid); end
    checks++; if (bus.instr_out !== 8'h13) begin errors++; $display("FAIL single_word: got %h exp 13", bus.instr_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", count); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b exp 0", bus.out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    logic [7:0] exp_words [4] = '{8'hC5, 8'hB2, 8'h21, 8'h5F};
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b110, 1'b0, 4'h5); tick();
    drive(1'b1, 3'b101, 1'b1, 4'h2); tick();
    drive(1'b1, 3'b001, 1'b0, 4'h1); tick();
    drive(1'b1, 3'b010, 1'b1, 4'hF); tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", bus.in_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", count); end
    drive(1'b1, 3'b000, 1'b0, 4'h7);
    tick(); tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d exp 4", count); end
    checks++; if (bus.instr_out !== 8'hC5) begin errors++; $display("FAIL full_hold_head: got %h exp c5", bus.instr_out); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.instr_out !== exp_words[i]) begin
        errors++; $display("FAIL drain_word[%0d]: got v=%b %h exp v=1 %h", i, bus.out_valid, bus.instr_out, exp_words[i]);
      end
      if (i == 0) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_push: got %b exp 0", bus.in_ready); end
      end
      if (i == 1) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b exp 1", bus.in_ready); end
      end
      tick();
      if (i == 1) drive(1'b0, 3'b000, 1'b0, 4'h0);
    end
    checks++; if (bus.instr_out !== 8'h07 || count !== 3'd1) begin
      errors++; $display("FAIL fifth_entry: got %h cnt=%0d exp 07 cnt=1", bus.instr_out, count);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL fill_empty: got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, count);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b111, 1'b1, 4'hA); tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    checks++; if (bus.instr_out !== 8'hE0) begin errors++; $display("FAIL illegal_word: got %h exp e0", bus.instr_out); end
    checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b exp 1", illegal_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL illegal_clr: got %b exp 0", illegal_err); end
    drive(1'b1, 3'b111, 1'b0, 4'h0); tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    checks++; if (bus.instr_out !== 8'hE0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL legal_nop_word: got v=%b %h exp v=1 e0", bus.out_valid, bus.instr_out);
    end
    checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL legal_nop_flag: got %b exp 0", illegal_err); end
    tick();
    drive(1'b1, 3'b111, 1'b0, 4'h1); err_clr = 1'b1; tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0); err_clr = 1'b0;
    checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b exp 1", illegal_err); end
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b000, 1'b0, 4'(i));
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.instr_out !== 8'(i) || count !== 3'd1) begin
        errors++; $display("FAIL stream[%0d]: got v=%b %h cnt=%0d exp v=1 %h cnt=1", i, bus.out_valid, bus.instr_out, count, 8'(i));
      end
    end
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL stream_end: got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, count);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'b000, 1'b0, 4'(i)); tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", count); end
    drive(1'b1, 3'b000, 1'b0, 4'h9); bus.out_ready = 1'b1; flush = 1'b1;
    tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0); flush = 1'b0;
    checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty[%0d]: got %b exp 0", i, bus.out_valid); end
    end
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 4'hA); tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    checks++; if (bus.instr_out !== 8'h0A || count !== 3'd1) begin
      errors++; $display("FAIL flush_resume: got %h cnt=%0d exp 0a cnt=1", bus.instr_out, count);
    end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 1'b1, 4'h1); tick();
    drive(1'b1, 3'b000, 1'b1, 4'h2); tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    checks++; if (count !== 3'd2 || bus.instr_out !== 8'h11) begin
      errors++; $display("FAIL pre_reset: got %h cnt=%0d exp 11 cnt=2", bus.instr_out, count);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0 || bus.instr_out !== 8'h00) begin
      errors++; $display("FAIL async_reset: got v=%b cnt=%0d %h exp v=0 cnt=0 00", bus.out_valid, count, bus.instr_out);
    end
    tick();
    #2 reset = 1'b0;
    tick();
    drive(1'b1, 3'b000, 1'b1, 4'h3); tick();
    drive(1'b0, 3'b000, 1'b0, 4'h0);
    checks++; if (bus.out_valid !== 1'b1 || bus.instr_out !== 8'h13 || count !== 3'd1) begin
      errors++; $display("FAIL post_reset: got v=%b %h cnt=%0d exp v=1 13 cnt=1", bus.out_valid, bus.instr_out, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
